// File: rtl/wb_multiport_fifo.sv
// Multi-port first-word-fall-through FIFO for the WriteBack stage.
// Several functional units push completion records in one cycle; the commit
// side sees the RD_PORTS oldest entries and pops up to rd_pop of them per cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear (pipeline squash), beats write and pop
//   wr_valid/data   per-lane write requests, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_ready        all lanes may write this cycle (free >= WR_PORTS)
//   rd_valid/data   oldest RD_PORTS entries, lane 0 oldest, zero when absent
//   rd_pop          number of oldest entries to remove this cycle
//   count, free     occupancy and free slots
//   full, empty, almost_full        status decoded from registered count
//   overflow_err, underflow_err     sticky error flags, cleared only by rst_n
module wb_multiport_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned WR_PORTS     = 2,
    parameter int unsigned RD_PORTS     = 2,
    parameter int unsigned AFULL_THRESH = FIFO_DEPTH - WR_PORTS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [WR_PORTS-1:0]              wr_valid,
    input  logic [WR_PORTS*DATA_WIDTH-1:0]   wr_data,
    output logic                             wr_ready,
    output logic [RD_PORTS-1:0]              rd_valid,
    output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    input  logic [$clog2(RD_PORTS+1)-1:0]    rd_pop,
    output logic [$clog2(FIFO_DEPTH):0]      count,
    output logic [$clog2(FIFO_DEPTH):0]      free,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             overflow_err,
    output logic                             underflow_err
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned POP_W  = $clog2(RD_PORTS + 1);
    localparam int unsigned WCNT_W = $clog2(WR_PORTS + 1);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Combinational helpers
    logic [WCNT_W-1:0]     lane_off [WR_PORTS];
    logic [WCNT_W-1:0]     n_wr;
    logic                  wr_accept;
    logic [CNT_W-1:0]      n_wr_acc;
    logic [CNT_W-1:0]      pop_ext;
    logic [CNT_W-1:0]      n_pop;
    logic                  pop_under;
    logic                  wr_over;
    logic [CNT_W-1:0]      count_next;

    // Status decode from registered count only
    always_comb begin
        count       = count_q;
        free        = CNT_W'(FIFO_DEPTH) - count_q;
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        empty       = (count_q == '0);
        almost_full = (count_q >= CNT_W'(AFULL_THRESH));
        wr_ready    = (free >= CNT_W'(WR_PORTS));
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    // Compaction: each valid lane's slot offset is the number of valid lanes below it
    always_comb begin
        n_wr = '0;
        for (int i = 0; i < int'(WR_PORTS); i++) begin
            lane_off[i] = n_wr;
            n_wr        = n_wr + WCNT_W'(wr_valid[i]);
        end
    end

    // Acceptance uses pre-pop free, so popping slots are never overwritten
    always_comb begin
        wr_accept  = wr_ready && !flush;
        wr_over    = (|wr_valid) && !wr_ready;
        n_wr_acc   = wr_accept ? CNT_W'(n_wr) : '0;
        pop_ext    = CNT_W'(rd_pop);
        pop_under  = (pop_ext > count_q);
        n_pop      = pop_under ? count_q : pop_ext;
        count_next = count_q + n_wr_acc - n_pop;
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_over) begin
                overflow_q <= 1'b1;
            end
            if (pop_under) begin
                underflow_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                wr_ptr  <= wr_ptr + PTR_W'(n_wr_acc);
                rd_ptr  <= rd_ptr + PTR_W'(n_pop);
                count_q <= count_next;
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < int'(WR_PORTS); i++) begin
                if (wr_valid[i]) begin
                    mem[wr_ptr + PTR_W'(lane_off[i])] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // FWFT read view; absent lanes read as zero so reset shows rd_data=0
    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        for (int i = 0; i < int'(RD_PORTS); i++) begin
            if (CNT_W'(i) < count_q) begin
                rd_valid[i]                         = 1'b1;
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

    // POP_W only documents the rd_pop width
    localparam int unsigned POP_W_CHECK = POP_W;

endmodule

// File: tb/tb_wb_multiport_fifo.sv
// Scoreboard bench for wb_multiport_fifo: stimulus pushes expected entries,
// a negedge monitor pops and compares every entry the DUT hands out on a pop.
module tb_wb_multiport_fifo;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [1:0]    wr_valid;
    logic [63:0]   wr_data;
    logic          wr_ready;
    logic [1:0]    rd_valid;
    logic [63:0]   rd_data;
    logic [1:0]    rd_pop;
    logic [4:0]    count;
    logic [4:0]    free;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow_err;
    logic          underflow_err;

    wb_multiport_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_pop       (rd_pop),
        .count        (count),
        .free         (free),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    int          mcount = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every entry handed out on a pop must be the scoreboard's oldest
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (i < int'(rd_pop) && rd_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_extra: lane %0d got %0h expected no entry", i, rd_data[i*DW +: DW]);
                    end else begin
                        chk("pop_data", 64'(rd_data[i*DW +: DW]), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the bench's own occupancy model decides acceptance
    task automatic drive(input logic [1:0] wv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] pop, input logic fl);
        int np;
        bit acc;
        wr_valid = wv;
        wr_data  = {d1, d0};
        rd_pop   = pop;
        flush    = fl;
        np  = (int'(pop) > mcount) ? mcount : int'(pop);
        acc = !fl && ((16 - mcount) >= 2);
        if (acc) begin
            if (wv[0]) begin exp_q.push_back(d0); mcount++; end
            if (wv[1]) begin exp_q.push_back(d1); mcount++; end
        end
        mcount = mcount - np;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            mcount = 0;
        end
        wr_valid = '0;
        rd_pop   = '0;
        flush    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_afull"}, 64'(almost_full), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_free"}, 64'(free), 64'd16);
        chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data"}, rd_data, 64'd0);
        chk({tag, "_ovf"}, 64'(overflow_err), 64'd0);
        chk({tag, "_udf"}, 64'(underflow_err), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = '0;
        wr_data  = '0;
        rd_pop   = '0;
        #3;
        chk_reset_vals("in_reset");
        #14;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("idle");

        // Two-lane then upper-lane-only write, FWFT view, then pop two
        drive(2'b11, 32'hA, 32'hB, 2'd0, 1'b0);
        drive(2'b10, 32'h0, 32'hC, 2'd0, 1'b0);
        chk("cnt3", 64'(count), 64'd3);
        chk("cnt3_rd_valid", 64'(rd_valid), 64'b11);
        chk("cnt3_lane0", 64'(rd_data[31:0]), 64'hA);
        chk("cnt3_lane1", 64'(rd_data[63:32]), 64'hB);
        drive(2'b00, 0, 0, 2'd2, 1'b0);
        chk("after_pop_rd_valid", 64'(rd_valid), 64'b01);
        chk("after_pop_lane0", 64'(rd_data[31:0]), 64'hC);
        chk("after_pop_lane1", 64'(rd_data[63:32]), 64'h0);
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        chk("drained", 64'(empty), 64'd1);

        // Fill to 14, then 16, then an overflowing write, then flush
        for (int k = 0; k < 7; k++) drive(2'b11, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 2'd0, 1'b0);
        chk("c14_count", 64'(count), 64'd14);
        chk("c14_afull", 64'(almost_full), 64'd1);
        chk("c14_wr_ready", 64'(wr_ready), 64'd1);
        chk("c14_free", 64'(free), 64'd2);
        drive(2'b11, 32'h10E, 32'h10F, 2'd0, 1'b0);
        chk("c16_count", 64'(count), 64'd16);
        chk("c16_full", 64'(full), 64'd1);
        chk("c16_wr_ready", 64'(wr_ready), 64'd0);
        drive(2'b01, 32'hDEAD, 32'h0, 2'd0, 1'b0);
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag", 64'(overflow_err), 64'd1);
        drive(2'b00, 0, 0, 2'd0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ovf_kept", 64'(overflow_err), 64'd1);

        // Simultaneous write and pop at count 5
        drive(2'b11, 32'h200, 32'h201, 2'd0, 1'b0);
        drive(2'b11, 32'h202, 32'h203, 2'd0, 1'b0);
        drive(2'b01, 32'h204, 32'h0, 2'd0, 1'b0);
        chk("c5_count", 64'(count), 64'd5);
        drive(2'b11, 32'h205, 32'h206, 2'd2, 1'b0);
        chk("wr_pop_count", 64'(count), 64'd5);
        chk("wr_pop_lane0", 64'(rd_data[31:0]), 64'h202);
        drive(2'b00, 0, 0, 2'd2, 1'b0);
        drive(2'b00, 0, 0, 2'd2, 1'b0);
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        chk("c5_drained", 64'(count), 64'd0);

        // Wrap: pointers to 0, fill 0..14 (wr_ptr=15), pop 14, write straddles 15->0
        drive(2'b00, 0, 0, 2'd0, 1'b1);
        for (int k = 0; k < 7; k++) drive(2'b11, 32'(2*k), 32'(2*k+1), 2'd0, 1'b0);
        drive(2'b01, 32'hE, 32'h0, 2'd0, 1'b0);
        chk("wrap_c15", 64'(count), 64'd15);
        for (int k = 0; k < 7; k++) drive(2'b00, 0, 0, 2'd2, 1'b0);
        drive(2'b11, 32'h10, 32'h11, 2'd0, 1'b0);
        chk("wrap_count", 64'(count), 64'd3);
        chk("wrap_lane0", 64'(rd_data[31:0]), 64'hE);
        chk("wrap_lane1", 64'(rd_data[63:32]), 64'h10);
        drive(2'b00, 0, 0, 2'd2, 1'b0);
        chk("wrap_read_straddle", 64'(rd_data[31:0]), 64'h11);
        drive(2'b00, 0, 0, 2'd1, 1'b0);

        // Underflow: count 1, pop 2
        drive(2'b01, 32'h300, 32'h0, 2'd0, 1'b0);
        drive(2'b00, 0, 0, 2'd2, 1'b0);
        chk("udf_count", 64'(count), 64'd0);
        chk("udf_flag", 64'(underflow_err), 64'd1);

        // Flush at count 7 with a simultaneous write
        for (int k = 0; k < 3; k++) drive(2'b11, 32'h400 + 32'(2*k), 32'h401 + 32'(2*k), 2'd0, 1'b0);
        drive(2'b01, 32'h406, 32'h0, 2'd0, 1'b0);
        chk("c7_count", 64'(count), 64'd7);
        drive(2'b11, 32'h500, 32'h501, 2'd0, 1'b1);
        chk("flush_wr_count", 64'(count), 64'd0);
        chk("flush_wr_empty", 64'(empty), 64'd1);
        chk("flush_udf_kept", 64'(underflow_err), 64'd1);

        // Asynchronous reset in the middle of a burst
        drive(2'b11, 32'h600, 32'h601, 2'd0, 1'b0);
        wr_valid = 2'b11;
        wr_data  = {32'h603, 32'h602};
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        exp_q.delete();
        mcount   = 0;
        wr_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sanity after reset
        drive(2'b01, 32'h700, 32'h0, 2'd0, 1'b0);
        chk("post_rst_lane0", 64'(rd_data[31:0]), 64'h700);
        drive(2'b00, 0, 0, 2'd1, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
